// File: rtl/seg_disp_pkg.sv
// Shared types, glyphs and sizing helpers for the 7-segment display controller.
// Glyphs are active-high {g,f,e,d,c,b,a}; the top applies board polarity.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Entry n is the glyph for nibble n: 0-9, A, b, C, d, E, F.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // 4*ceil((data_w+2)/3) bits hold every BCD digit of a data_w-bit value.
    function automatic int bcd_width(input int data_w);
        return 4 * ((data_w + 4) / 3);
    endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter, one add-3/shift step per clock.
// Latency: DATA_W cycles after start; done is high during the cycle whose edge lands the final shift.
// Backpressure: none; start while busy is the caller's responsibility to avoid.
module bcd_double_dabble
    import seg_disp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [DATA_W-1:0]                   bin,
    output logic                                busy,
    output logic                                done,
    output logic [bcd_width(DATA_W)-1:0]        bcd
);

    localparam int BCD_W = bcd_width(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        adj   = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        if (start) begin
            bin_d = bin;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    // Flagged one cycle early so the caller's FSM can read bcd on the very next edge.
    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment controller: captures a value and renders hex or decimal with blanking/overflow.
// Latency: hex done 1 edge after load, decimal DATA_W+1 edges after load; seg registered.
// Backpressure: load is ignored while busy, nothing is queued.
module seg_display_ctrl
    import seg_disp_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int NUM_DIGITS     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DATA_W-1:0]       value,
    input  logic                    mode,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int BCD_W = bcd_width(DATA_W);
    localparam int EXT_W = ((BCD_W > 4 * NUM_DIGITS) ? BCD_W : 4 * NUM_DIGITS) + 4;

    function automatic logic [6:0] drive(input logic [6:0] g);
        return SEG_ACTIVE_LOW ? ~g : g;
    endfunction

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       val_q, val_d;
    logic                    mode_q, mode_d;
    logic                    blank_q, blank_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;

    logic                    dd_start, dd_busy, dd_done;
    logic [BCD_W-1:0]        dd_bcd;
    logic [EXT_W-1:0]        src_ext;
    logic                    img_ovf, lead;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [6:0]              glyph;
    logic [7*NUM_DIGITS-1:0] img;

    bcd_double_dabble #(.DATA_W(DATA_W)) u_dd (
        .clk   (clk),
        .reset (reset),
        .start (dd_start),
        .bin   (value),
        .busy  (dd_busy),
        .done  (dd_done),
        .bcd   (dd_bcd)
    );

    // Render the captured digits; both number bases share the same nibble view.
    always_comb begin
        src_ext = '0;
        if (mode_q) src_ext[BCD_W-1:0]  = dd_bcd;
        else        src_ext[DATA_W-1:0] = val_q;
        img_ovf  = |(src_ext >> (4 * NUM_DIGITS));
        lead     = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (src_ext[4*i +: 4] != 4'd0) lead = 1'b0;
            lz_blank[i] = lead & blank_q;
        end
        glyph = SEG_BLANK;
        img   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (img_ovf)          glyph = SEG_DASH;
            else if (lz_blank[i]) glyph = SEG_BLANK;
            else                  glyph = GLYPH_TBL[src_ext[4*i +: 4]];
            img[7*i +: 7] = drive(glyph);
        end
    end

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        mode_d   = mode_q;
        blank_d  = blank_q;
        seg_d    = seg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        dd_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d    = value;
                    mode_d   = mode;
                    blank_d  = blank_lz;
                    dd_start = mode;
                    state_d  = mode ? CONVERT : UPDATE;
                end
            end
            CONVERT: begin
                if (dd_done || !dd_busy) state_d = UPDATE;
            end
            UPDATE: begin
                seg_d   = img;
                ovf_d   = img_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            mode_q  <= 1'b0;
            blank_q <= 1'b0;
            seg_q   <= {NUM_DIGITS{drive(SEG_BLANK)}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with an arithmetic reference model checked every cycle.
module tb_seg_display_ctrl;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy, done, overflow;
    logic [27:0] seg;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    seg_display_ctrl #(.DATA_W(16), .NUM_DIGITS(NDIG), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Returns {overflow, seg} for an active-low board, from plain digit arithmetic.
    function automatic logic [28:0] model_img(input int v, input bit dec, input bit blk);
        int base, p, msd;
        int d [NDIG];
        logic [27:0] s;
        bit ov;
        base = dec ? 10 : 16;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            d[i] = (v / p) % base;
            p = p * base;
        end
        ov = (v >= p);
        msd = 0;
        for (int i = 0; i < NDIG; i++) if (d[i] != 0) msd = i;
        s = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (ov)                  s[7*i +: 7] = 7'h3F;
            else if (blk && i > msd) s[7*i +: 7] = 7'h7F;
            else                     s[7*i +: 7] = ~glyph_ah[d[i]];
        end
        return {ov, s};
    endfunction

    // Timing model: a countdown of edges from capture to display update.
    logic        m_busy, m_done;
    logic [28:0] m_img;
    int          m_left;
    int          m_val;
    bit          m_mode, m_blank;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_img  <= {1'b0, 28'hFFFFFFF};
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (load) begin
                    m_busy  <= 1'b1;
                    m_left  <= mode ? 17 : 1;
                    m_val   <= int'(value);
                    m_mode  <= mode;
                    m_blank <= blank_lz;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_img  <= model_img(m_val, m_mode, m_blank);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("overflow", 32'(overflow), 32'(m_img[28]));
            chk("seg", 32'(seg), 32'(m_img[27:0]));
        end
    end

    // Issue one load and return the number of edges after capture until done is seen.
    task automatic run_op(input logic [15:0] v, input bit dec, input bit blk, output int cyc);
        @(negedge clk);
        value = v; mode = dec; blank_lz = blk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    int cyc, pulses;

    initial begin
        // Reset for two cycles.
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_seg", 32'(seg), 32'h0FFFFFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        run_op(16'h1A3F, 1'b0, 1'b0, cyc);
        chk("hex_lat", 32'(cyc), 32'd1);
        chk("hex_1a3f", 32'(seg), 32'({7'h79, 7'h08, 7'h30, 7'h0E}));
        chk("hex_ovf", 32'(overflow), 32'd0);

        run_op(16'd1234, 1'b1, 1'b0, cyc);
        chk("dec_lat", 32'(cyc), 32'd17);
        chk("dec_1234", 32'(seg), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        run_op(16'd65535, 1'b1, 1'b1, cyc);
        chk("dec_ovf_flag", 32'(overflow), 32'd1);
        chk("dec_ovf_dash", 32'(seg), 32'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));

        run_op(16'h0005, 1'b0, 1'b1, cyc);
        chk("hex_blank5", 32'(seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
        chk("ovf_cleared", 32'(overflow), 32'd0);
        run_op(16'h0000, 1'b0, 1'b1, cyc);
        chk("hex_blank0", 32'(seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        // Boundaries handled by the model: full-width hex, largest/smallest decimal fits.
        run_op(16'hFFFF, 1'b0, 1'b0, cyc);
        run_op(16'd9999, 1'b1, 1'b1, cyc);
        run_op(16'd10000, 1'b1, 1'b0, cyc);
        chk("dec_10000_ovf", 32'(overflow), 32'd1);
        run_op(16'd0, 1'b1, 1'b1, cyc);
        run_op(16'h0A00, 1'b0, 1'b1, cyc);
        chk("hex_blank_a00", 32'(seg), 32'({7'h7F, 7'h08, 7'h40, 7'h40}));

        // Load while busy is dropped.
        @(negedge clk);
        value = 16'd99; mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        value = 16'd77; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("drop_pulses", 32'(pulses), 32'd1);
        chk("drop_seg99", 32'(seg), 32'({7'h40, 7'h40, 7'h10, 7'h10}));

        // Reset in the middle of a conversion aborts without done.
        @(negedge clk);
        value = 16'd4321; mode = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_seg", 32'(seg), 32'h0FFFFFFF);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        run_op(16'h00C7, 1'b0, 1'b1, cyc);
        chk("post_abort", 32'(seg), 32'({7'h7F, 7'h7F, 7'h46, 7'h78}));

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
